// File: rtl/vga_timing_gen_pkg.sv
// Shared types, mode constant sets and elaboration helpers for the VGA raster
// timing generator.
package vga_timing_pkg;

   typedef enum logic [1:0] {
      ST_SYNC       = 2'd0,
      ST_BACKPORCH  = 2'd1,
      ST_ACTIVE     = 2'd2,
      ST_FRONTPORCH = 2'd3
   } axis_state_e;

   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
      logic        pol;
   } axis_mode_t;

   typedef struct packed {
      axis_mode_t h;
      axis_mode_t v;
   } vga_mode_t;

   localparam vga_mode_t MODE_640X480_60 = '{
      h: '{active: 640, fp: 16, sync: 96,  bp: 48, pol: 1'b0},
      v: '{active: 480, fp: 10, sync: 2,   bp: 29, pol: 1'b0}
   };

   localparam vga_mode_t MODE_800X600_72 = '{
      h: '{active: 800, fp: 56, sync: 120, bp: 64, pol: 1'b1},
      v: '{active: 600, fp: 37, sync: 6,   bp: 23, pol: 1'b1}
   };

   function automatic int axis_total(int active, int fp, int sync, int bp);
      return sync + bp + active + fp;
   endfunction

   // True when a CW-bit counter can reach the larger axis total minus one.
   function automatic bit width_ok(int cw, int h_total, int v_total);
      longint max_count;
      max_count = longint'((h_total > v_total) ? h_total : v_total) - 64'sd1;
      return max_count < (64'sd1 <<< cw);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen and consumed by the renderer.
interface vga_timing_gen_if #(
   parameter int CW = 10
);
   logic          hsync;
   logic          vsync;
   logic          vidon;
   logic [CW-1:0] hc;
   logic [CW-1:0] vc;
   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic          line_start;
   logic          frame_start;

   modport master (
      output hsync, vsync, vidon, hc, vc, x, y, line_start, frame_start
   );

   modport slave (
      input  hsync, vsync, vidon, hc, vc, x, y, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: counts steps modulo the axis total and tracks the region.
// state         | meaning
// ST_SYNC       | count in [0, SYNC)
// ST_BACKPORCH  | count in [SYNC, SYNC+BP)
// ST_ACTIVE     | count in [SYNC+BP, SYNC+BP+ACTIVE)
// ST_FRONTPORCH | count in [SYNC+BP+ACTIVE, TOTAL)
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter bit POL    = 1'b0,
   parameter int CW     = 10
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          i_step,
   output logic [CW-1:0] o_count,
   output logic          o_wrap,
   output logic          o_sync,
   output logic          o_active_nxt,
   output logic [CW-1:0] o_coord_nxt
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [CW-1:0] C_LAST = CW'(TOTAL - 1);
   localparam logic [CW-1:0] C_BP0  = CW'(SYNC);
   localparam logic [CW-1:0] C_A0   = CW'(SYNC + BP);
   localparam logic [CW-1:0] C_FP0  = CW'(SYNC + BP + ACTIVE);

   axis_state_e   r_state;
   axis_state_e   w_state_nxt;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic          r_sync;
   logic          w_sync_nxt;

   assign o_wrap  = (r_count == C_LAST);
   assign o_count = r_count;
   assign o_sync  = r_sync;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= ST_SYNC;
         r_count <= '0;
         r_sync  <= POL;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_sync  <= w_sync_nxt;
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      if (i_step) begin
         w_count_nxt = o_wrap ? '0 : r_count + 1'b1;
      end
      w_state_nxt = r_state;
      case (r_state)
         ST_SYNC:       if (w_count_nxt == C_BP0) w_state_nxt = ST_BACKPORCH;
         ST_BACKPORCH:  if (w_count_nxt == C_A0)  w_state_nxt = ST_ACTIVE;
         ST_ACTIVE:     if (w_count_nxt == C_FP0) w_state_nxt = ST_FRONTPORCH;
         ST_FRONTPORCH: if (w_count_nxt == '0)    w_state_nxt = ST_SYNC;
         default:       w_state_nxt = ST_SYNC;
      endcase
   end

   // Decodes look at the next state so registered outputs line up with the count.
   always_comb begin
      w_sync_nxt   = (w_state_nxt == ST_SYNC) ? POL : ~POL;
      o_active_nxt = (w_state_nxt == ST_ACTIVE);
      o_coord_nxt  = o_active_nxt ? (w_count_nxt - C_A0) : '0;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: two axis counters plus registered video window,
// coordinates and line/frame strobes, all aligned to hc/vc.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = MODE_640X480_60.h.active,
   parameter int H_FP     = MODE_640X480_60.h.fp,
   parameter int H_SYNC   = MODE_640X480_60.h.sync,
   parameter int H_BP     = MODE_640X480_60.h.bp,
   parameter int V_ACTIVE = MODE_640X480_60.v.active,
   parameter int V_FP     = MODE_640X480_60.v.fp,
   parameter int V_SYNC   = MODE_640X480_60.v.sync,
   parameter int V_BP     = MODE_640X480_60.v.bp,
   parameter bit HS_POL   = MODE_640X480_60.h.pol,
   parameter bit VS_POL   = MODE_640X480_60.v.pol,
   parameter int CW       = 10
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              pix_en,
   vga_timing_gen_if.master  vif
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (!width_ok(CW, H_TOTAL, V_TOTAL)) begin : g_width_check
      $error("vga_timing_gen: CW=%0d cannot hold H_TOTAL=%0d / V_TOTAL=%0d",
             CW, H_TOTAL, V_TOTAL);
   end

   logic [CW-1:0] w_hc, w_vc;
   logic [CW-1:0] w_h_coord_nxt, w_v_coord_nxt;
   logic          w_h_wrap, w_v_wrap;
   logic          w_hsync, w_vsync;
   logic          w_h_active_nxt, w_v_active_nxt;
   logic          w_v_step;
   logic          w_vidon_nxt;

   logic          r_vidon;
   logic [CW-1:0] r_x, r_y;
   logic          r_line_start, r_frame_start;

   assign w_v_step    = pix_en & w_h_wrap;
   assign w_vidon_nxt = w_h_active_nxt & w_v_active_nxt;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
   ) u_h_axis (
      .clk          (clk),
      .clr          (clr),
      .i_step       (pix_en),
      .o_count      (w_hc),
      .o_wrap       (w_h_wrap),
      .o_sync       (w_hsync),
      .o_active_nxt (w_h_active_nxt),
      .o_coord_nxt  (w_h_coord_nxt)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
   ) u_v_axis (
      .clk          (clk),
      .clr          (clr),
      .i_step       (w_v_step),
      .o_count      (w_vc),
      .o_wrap       (w_v_wrap),
      .o_sync       (w_vsync),
      .o_active_nxt (w_v_active_nxt),
      .o_coord_nxt  (w_v_coord_nxt)
   );

   // Strobes fire on the edge that loads hc=0, never for the reset-loaded zero.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_vidon       <= 1'b0;
         r_x           <= '0;
         r_y           <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_vidon       <= w_vidon_nxt;
         r_x           <= w_vidon_nxt ? w_h_coord_nxt : '0;
         r_y           <= w_v_coord_nxt;
         r_line_start  <= pix_en & w_h_wrap;
         r_frame_start <= pix_en & w_h_wrap & w_v_wrap;
      end
   end

   assign vif.hsync       = w_hsync;
   assign vif.vsync       = w_vsync;
   assign vif.vidon       = r_vidon;
   assign vif.hc          = w_hc;
   assign vif.vc          = w_vc;
   assign vif.x           = r_x;
   assign vif.y           = r_y;
   assign vif.line_start  = r_line_start;
   assign vif.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance and a tiny override
// instance, each compared every cycle against a pixel-count raster model.
module tb_vga_timing_gen;

   typedef struct {
      int ha, hfp, hsw, hbp;
      int va, vfp, vsw, vbp;
      int hpol, vpol;
   } mode_t;

   typedef struct {
      int hc, vc, hsync, vsync, vid, x, y;
   } exp_t;

   localparam mode_t MA = '{ha: 640, hfp: 16, hsw: 96, hbp: 48,
                            va: 480, vfp: 10, vsw: 2, vbp: 29, hpol: 0, vpol: 0};
   localparam mode_t MB = '{ha: 4, hfp: 1, hsw: 2, hbp: 1,
                            va: 3, vfp: 1, vsw: 1, vbp: 1, hpol: 1, vpol: 0};
   localparam int HT_A = 800, VT_A = 521;
   localparam int HT_B = 8,   VT_B = 6;

   logic clk = 1'b0;
   logic clr_a = 1'b1, pen_a = 1'b0;
   logic clr_b = 1'b1, pen_b = 1'b0;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int na = 0, nb = 0;
   bit ls_a = 0, fs_a = 0, ls_b = 0, fs_b = 0;
   bit rec_a = 0;
   int ls_cycles[$];

   vga_timing_gen_if #(.CW(10)) if_a ();
   vga_timing_gen_if #(.CW(10)) if_b ();

   vga_timing_gen dut_a (
      .clk    (clk),
      .clr    (clr_a),
      .pix_en (pen_a),
      .vif    (if_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b0), .CW(10)
   ) dut_b (
      .clk    (clk),
      .clr    (clr_b),
      .pix_en (pen_b),
      .vif    (if_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Raster position = number of enabled edges since reset; strobes mark the
   // edge whose new position starts a line / frame.
   always @(posedge clk or posedge clr_a) begin
      if (clr_a) begin
         na <= 0; ls_a <= 0; fs_a <= 0;
      end else if (pen_a) begin
         na   <= na + 1;
         ls_a <= ((na + 1) % HT_A) == 0;
         fs_a <= ((na + 1) % (HT_A * VT_A)) == 0;
      end else begin
         ls_a <= 0; fs_a <= 0;
      end
   end

   always @(posedge clk or posedge clr_b) begin
      if (clr_b) begin
         nb <= 0; ls_b <= 0; fs_b <= 0;
      end else if (pen_b) begin
         nb   <= nb + 1;
         ls_b <= ((nb + 1) % HT_B) == 0;
         fs_b <= ((nb + 1) % (HT_B * VT_B)) == 0;
      end else begin
         ls_b <= 0; fs_b <= 0;
      end
   end

   function automatic exp_t model(mode_t m, int n);
      exp_t e;
      int ht  = m.hsw + m.hbp + m.ha + m.hfp;
      int vt  = m.vsw + m.vbp + m.va + m.vfp;
      int ha0 = m.hsw + m.hbp;
      int va0 = m.vsw + m.vbp;
      bit hact, vact;
      e.hc  = n % ht;
      e.vc  = (n / ht) % vt;
      hact  = (e.hc >= ha0) && (e.hc < ha0 + m.ha);
      vact  = (e.vc >= va0) && (e.vc < va0 + m.va);
      e.hsync = (e.hc < m.hsw) ? m.hpol : 1 - m.hpol;
      e.vsync = (e.vc < m.vsw) ? m.vpol : 1 - m.vpol;
      e.vid = (hact && vact) ? 1 : 0;
      e.x   = (hact && vact) ? e.hc - ha0 : 0;
      e.y   = vact ? e.vc - va0 : 0;
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_all(input string tag, input mode_t m, input int n,
                          input bit els, input bit efs,
                          input logic hs, input logic vs, input logic vid,
                          input logic [9:0] hc, input logic [9:0] vc,
                          input logic [9:0] x, input logic [9:0] y,
                          input logic ls, input logic fs);
      exp_t e;
      e = model(m, n);
      chk({tag, ".hc"},    int'(hc),  e.hc);
      chk({tag, ".vc"},    int'(vc),  e.vc);
      chk({tag, ".hsync"}, int'(hs),  e.hsync);
      chk({tag, ".vsync"}, int'(vs),  e.vsync);
      chk({tag, ".vidon"}, int'(vid), e.vid);
      chk({tag, ".x"},     int'(x),   e.x);
      chk({tag, ".y"},     int'(y),   e.y);
      chk({tag, ".line_start"},  int'(ls), int'(els));
      chk({tag, ".frame_start"}, int'(fs), int'(efs));
   endtask

   always @(negedge clk) begin
      cmp_all("a", MA, na, ls_a, fs_a, if_a.hsync, if_a.vsync, if_a.vidon,
              if_a.hc, if_a.vc, if_a.x, if_a.y, if_a.line_start, if_a.frame_start);
      cmp_all("b", MB, nb, ls_b, fs_b, if_b.hsync, if_b.vsync, if_b.vidon,
              if_b.hc, if_b.vc, if_b.x, if_b.y, if_b.line_start, if_b.frame_start);
      if (rec_a && if_a.line_start) ls_cycles.push_back(cyc);
   end

   task automatic tick(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      tick(3);
      chk("a.rst.hc", int'(if_a.hc), 0);
      chk("a.rst.vc", int'(if_a.vc), 0);
      chk("a.rst.hsync", int'(if_a.hsync), 0);
      chk("a.rst.vsync", int'(if_a.vsync), 0);
      chk("a.rst.vidon", int'(if_a.vidon), 0);
      chk("a.rst.line_start", int'(if_a.line_start), 0);
      chk("b.rst.hsync", int'(if_b.hsync), 1);

      // Default mode, pix_en held high.
      clr_a = 1'b0;
      pen_a = 1'b1;
      tick(1);     chk("a.e1.hc", int'(if_a.hc), 1);
      tick(2);     chk("a.e3.hc", int'(if_a.hc), 3);
                   chk("a.e3.line_start", int'(if_a.line_start), 0);
      tick(92);    chk("a.hc95.hsync", int'(if_a.hsync), 0);
      tick(1);     chk("a.hc96.hsync", int'(if_a.hsync), 1);
      tick(703);   chk("a.hc799.hc", int'(if_a.hc), 799);
                   chk("a.hc799.vc", int'(if_a.vc), 0);
      tick(1);     chk("a.wrap.hc", int'(if_a.hc), 0);
                   chk("a.wrap.vc", int'(if_a.vc), 1);
                   chk("a.wrap.line_start", int'(if_a.line_start), 1);
                   chk("a.wrap.frame_start", int'(if_a.frame_start), 0);
      tick(1);     chk("a.wrap1.line_start", int'(if_a.line_start), 0);
      tick(798);   chk("a.vc1.vsync", int'(if_a.vsync), 0);
      tick(1);     chk("a.vc2.vsync", int'(if_a.vsync), 1);
                   chk("a.vc2.vc", int'(if_a.vc), 2);
      tick(23343); chk("a.hc143.vidon", int'(if_a.vidon), 0);
                   chk("a.hc143.vc", int'(if_a.vc), 31);
      tick(1);     chk("a.hc144.vidon", int'(if_a.vidon), 1);
                   chk("a.hc144.x", int'(if_a.x), 0);
      tick(639);   chk("a.hc783.x", int'(if_a.x), 639);
                   chk("a.hc783.vidon", int'(if_a.vidon), 1);
      tick(1);     chk("a.hc784.vidon", int'(if_a.vidon), 0);
                   chk("a.hc784.x", int'(if_a.x), 0);

      // pix_en every fourth clock: line period in clk cycles.
      ls_cycles.delete();
      rec_a = 1'b1;
      for (int i = 0; i < 6800; i++) begin
         pen_a = (i % 4 == 0);
         tick(1);
      end
      rec_a = 1'b0;
      pen_a = 1'b0;
      chk("a.quarter.strobes", ls_cycles.size(), 3);
      if (ls_cycles.size() >= 3) begin
         chk("a.quarter.period0", ls_cycles[1] - ls_cycles[0], 3200);
         chk("a.quarter.period1", ls_cycles[2] - ls_cycles[1], 3200);
      end

      // Tiny override mode.
      clr_b = 1'b0;
      pen_b = 1'b1;
      tick(1);  chk("b.hc1.hsync", int'(if_b.hsync), 1);
      tick(1);  chk("b.hc2.hsync", int'(if_b.hsync), 0);
      tick(5);  chk("b.vc0.vsync", int'(if_b.vsync), 0);
      tick(1);  chk("b.vc1.vsync", int'(if_b.vsync), 1);
      tick(11); chk("b.e19.vidon", int'(if_b.vidon), 1);
                chk("b.e19.x", int'(if_b.x), 0);
                chk("b.e19.vc", int'(if_b.vc), 2);
      tick(3);  chk("b.e22.x", int'(if_b.x), 3);
      tick(1);  chk("b.e23.vidon", int'(if_b.vidon), 0);
      tick(12); chk("b.e35.y", int'(if_b.y), 2);
      tick(12); chk("b.e47.hc", int'(if_b.hc), 7);
                chk("b.e47.vc", int'(if_b.vc), 5);
      tick(1);  chk("b.frame.hc", int'(if_b.hc), 0);
                chk("b.frame.vc", int'(if_b.vc), 0);
                chk("b.frame.frame_start", int'(if_b.frame_start), 1);
                chk("b.frame.line_start", int'(if_b.line_start), 1);
      tick(1);  chk("b.frame1.frame_start", int'(if_b.frame_start), 0);
      tick(19); chk("b.e68.x", int'(if_b.x), 1);

      // Asynchronous clear mid-line.
      @(posedge clk);
      #2 clr_b = 1'b1;
      #1;
      chk("b.clr.hc", int'(if_b.hc), 0);
      chk("b.clr.vidon", int'(if_b.vidon), 0);
      chk("b.clr.x", int'(if_b.x), 0);
      chk("b.clr.hsync", int'(if_b.hsync), 1);
      tick(2);
      clr_b = 1'b0;
      tick(1);  chk("b.rel.hc", int'(if_b.hc), 1);

      // Random enables and occasional clears on both instances.
      for (int i = 0; i < 3000; i++) begin
         pen_a = ($urandom_range(0, 3) != 0);
         pen_b = ($urandom_range(0, 3) != 0);
         clr_b = ($urandom_range(0, 149) == 0);
         clr_a = ($urandom_range(0, 299) == 0);
         tick(1);
      end
      clr_a = 1'b0;
      clr_b = 1'b0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
